uart_prog_loader: RTL and testbench

UART program loader sitting directly upstream of the instruction and data memories. While the CPU is held in program mode, it receives a framed byte stream on the serial RX pin and assembles little-endian 32-bit words. It then writes those words through the `upg_*` write port into IFetch's instruction RAM or DMem's data RAM, and raises a sticky done flag once a frame passes its checksum. An optional ACK/NAK byte goes back on TX.

---
 rtl/uart_prog_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART program loader: receives A5-framed byte streams, writes little-endian words to
// instruction/data RAM through the upg_* port. Define UPG_TX_ACK_EN to build the ACK/NAK serializer.
module uart_prog_loader #(
  parameter int CLK_HZ       = 10_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        upg_rx_i,
  output logic        upg_clk_o,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_tx_o
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
  localparam int TO_LIM = TIMEOUT_BITS * DIV;
  localparam int TOW = $clog2(TO_LIM + 2);
  localparam logic [TOW-1:0] TO_MAX = TOW'(TO_LIM);
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [2:0] F_IDLE = 3'd0, F_TGT = 3'd1, F_CNTH = 3'd2, F_CNTL = 3'd3,
                         F_DATA = 3'd4, F_CHK = 3'd5;

  logic        rx_meta, rx_sync, rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        byte_valid, frame_err;

  assign upg_clk_o = upg_clk_i;

  // byte_valid is a one-cycle strobe with rx_sh holding the byte; there is no ready,
  // the frame FSM accepts every byte in the cycle it is offered.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= upg_rx_i;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_sync) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        RX_START: if (rx_cnt == HALF_M1) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_sync ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_DATA: if (rx_cnt == DIV_M1) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_sync, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_STOP: if (rx_cnt == DIV_M1) begin
          rx_cnt     <= '0;
          rx_state   <= RX_IDLE;
          byte_valid <= rx_sync;
          frame_err  <= !rx_sync;
        end else rx_cnt <= rx_cnt + 16'd1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [2:0]     f_state;
  logic           tgt;
  logic [7:0]     cnt_hi, csum, reply_byte;
  logic [15:0]    words_left;
  logic [13:0]    idx;
  logic [1:0]     bcnt;
  logic [31:0]    word;
  logic [TOW-1:0] to_cnt;
  logic           reply_req;
  logic [15:0]    count_w;

  assign count_w = {cnt_hi, rx_sh};

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      f_state    <= F_IDLE;
      tgt        <= 1'b0;
      cnt_hi     <= '0;
      csum       <= '0;
      words_left <= '0;
      idx        <= '0;
      bcnt       <= '0;
      word       <= '0;
      to_cnt     <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      reply_req  <= 1'b0;
      reply_byte <= '0;
    end else begin
      upg_wen_o <= 1'b0;
      reply_req <= 1'b0;
      if (f_state == F_IDLE || byte_valid) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
      if (byte_valid) begin
        case (f_state)
          F_IDLE: if (rx_sh == SYNC) begin
            f_state <= F_TGT;
            csum    <= '0;
          end
          F_TGT: if (rx_sh[7:1] != 7'd0) begin
            f_state    <= F_IDLE;
            reply_req  <= 1'b1;
            reply_byte <= NAK;
          end else begin
            tgt     <= rx_sh[0];
            csum    <= csum ^ rx_sh;
            f_state <= F_CNTH;
          end
          F_CNTH: begin
            cnt_hi  <= rx_sh;
            csum    <= csum ^ rx_sh;
            f_state <= F_CNTL;
          end
          F_CNTL: begin
            csum       <= csum ^ rx_sh;
            idx        <= '0;
            bcnt       <= '0;
            words_left <= count_w;
            if (count_w > 16'd16384) begin
              f_state    <= F_IDLE;
              reply_req  <= 1'b1;
              reply_byte <= NAK;
            end else f_state <= (count_w == 16'd0) ? F_CHK : F_DATA;
          end
          F_DATA: begin
            word <= {rx_sh, word[31:8]};
            csum <= csum ^ rx_sh;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              upg_wen_o  <= 1'b1;
              upg_adr_o  <= {tgt, idx};
              upg_dat_o  <= {rx_sh, word[31:8]};
              idx        <= idx + 14'd1;
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) f_state <= F_CHK;
            end
          end
          F_CHK: begin
            reply_req <= 1'b1;
            if (rx_sh == csum) begin
              upg_done_o <= 1'b1;
              reply_byte <= ACK;
            end else reply_byte <= NAK;
            f_state <= F_IDLE;
          end
          default: f_state <= F_IDLE;
        endcase
      end else if (f_state != F_IDLE && (frame_err || to_cnt > TO_MAX)) begin
        f_state    <= F_IDLE;
        reply_req  <= 1'b1;
        reply_byte <= NAK;
      end
    end
  end

`ifdef UPG_TX_ACK_EN
  logic        tx_busy, tx_pend, tx_line;
  logic [7:0]  tx_pend_byte;
  logic [8:0]  tx_sh;
  logic [3:0]  tx_left;
  logic [15:0] tx_cnt;

  // A reply queued while busy overwrites the single pending slot.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      tx_busy      <= 1'b0;
      tx_pend      <= 1'b0;
      tx_pend_byte <= '0;
      tx_sh        <= '1;
      tx_left      <= '0;
      tx_cnt       <= '0;
      tx_line      <= 1'b1;
    end else if (!tx_busy) begin
      if (reply_req || tx_pend) begin
        tx_busy <= 1'b1;
        tx_pend <= 1'b0;
        tx_line <= 1'b0;
        tx_sh   <= {1'b1, reply_req ? reply_byte : tx_pend_byte};
        tx_left <= 4'd9;
        tx_cnt  <= '0;
      end
    end else begin
      if (reply_req) begin
        tx_pend      <= 1'b1;
        tx_pend_byte <= reply_byte;
      end
      if (tx_cnt == DIV_M1) begin
        tx_cnt <= '0;
        if (tx_left == 4'd0) tx_busy <= 1'b0;
        else begin
          tx_line <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_left <= tx_left - 4'd1;
        end
      end else tx_cnt <= tx_cnt + 16'd1;
    end
  end

  assign upg_tx_o = tx_line;
`else
  logic unused_reply;
  assign unused_reply = ^{reply_req, reply_byte};
  assign upg_tx_o = 1'b1;
`endif
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed and randomized frames against a word-level model of the loader.
module tb_uart_prog_loader;
  localparam int DIV = 10;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        clk_o, wen, done, tx;
  logic [14:0] adr;
  logic [31:0] dat;

  uart_prog_loader #(.CLK_HZ(10_000_000), .BAUD(1_000_000), .TIMEOUT_BITS(40)) dut (
    .upg_clk_i(clk), .upg_rst_i(rst), .upg_rx_i(rx), .upg_clk_o(clk_o),
    .upg_wen_o(wen), .upg_adr_o(adr), .upg_dat_o(dat), .upg_done_o(done), .upg_tx_o(tx)
  );

  always #50 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int wen_long = 0, unstable = 0, tx_bad = 0;
  logic [46:0] exp_q[$], got_q[$];
  logic [7:0]  tx_q[$], fr_q[$];
  logic [31:0] wd_q[$];
  logic        mon_on = 1'b0, prev_wen = 1'b0, model_done = 1'b0;
  logic [46:0] last_wd = '0;
  logic [7:0]  unused_reply_tb;

  // Write monitor: collects strobes, checks 1-cycle width and hold-until-next-strobe.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rst) last_wd = '0;
      else if (wen) begin
        got_q.push_back({adr, dat});
        if (prev_wen) wen_long++;
        last_wd = {adr, dat};
      end else if ({adr, dat} !== last_wd) unstable++;
      prev_wen = wen & ~rst;
    end
  end

  // TX monitor: decodes 8N1 replies at mid-bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (DIV / 2) @(negedge clk);
      if (tx !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = tx;
      end
      repeat (DIV) @(negedge clk);
      if (tx === 1'b1) tx_q.push_back(b);
      else tx_bad++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time();
    end
    rx = stop_ok;
    bit_time();
    rx = 1'b1;
    if (!stop_ok) bit_time();
  endtask

  task automatic send_frame(input int bad_stop_at, input int gap_after, input int gap_bits);
    for (int i = 0; i < fr_q.size(); i++) begin
      send_byte(fr_q[i], i != bad_stop_at);
      if (i == gap_after) repeat (gap_bits) bit_time();
    end
  endtask

  // Frame from wd_q; count field given separately so oversize counts can be built.
  task automatic make_frame(input logic tgt, input int cnt, input logic [7:0] flip);
    logic [7:0] c;
    fr_q.delete();
    fr_q.push_back(8'hA5);
    fr_q.push_back({7'd0, tgt});
    fr_q.push_back(8'(cnt >> 8));
    fr_q.push_back(8'(cnt));
    for (int i = 0; i < wd_q.size(); i++)
      for (int k = 0; k < 4; k++) fr_q.push_back(8'(wd_q[i] >> (8 * k)));
    c = 8'h00;
    for (int i = 1; i < fr_q.size(); i++) c = c ^ fr_q[i];
    fr_q.push_back(c ^ flip);
  endtask

  task automatic expect_words(input logic tgt, input int k);
    for (int i = 0; i < k; i++) exp_q.push_back({tgt, 14'(i), wd_q[i]});
  endtask

  task automatic settle(input string tag, input logic [7:0] reply);
    repeat (15 * DIV) @(negedge clk);
    check({tag, " writes"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, " write"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
    check({tag, " done"}, 64'(done), 64'(model_done));
    unused_reply_tb = reply;
`ifdef UPG_TX_ACK_EN
    check({tag, " replies"}, 64'(tx_q.size()), 64'd1);
    if (tx_q.size() > 0) check({tag, " reply"}, 64'(tx_q[0]), 64'(reply));
`else
    check({tag, " replies"}, 64'(tx_q.size()), 64'd0);
    check({tag, " tx idle"}, 64'(tx), 64'd1);
`endif
    tx_q.delete();
  endtask

  task automatic rand_frame(input string tag, input logic bad);
    int n;
    logic t;
    wd_q.delete();
    n = $urandom_range(1, 3);
    t = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) wd_q.push_back($urandom);
    make_frame(t, n, bad ? 8'($urandom_range(1, 255)) : 8'h00);
    expect_words(t, n);
    if (!bad) model_done = 1'b1;
    send_frame(-1, -1, 0);
    settle(tag, bad ? NAK : ACK);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst wen", 64'(wen), 64'd0);
    check("rst adr", 64'(adr), 64'd0);
    check("rst dat", 64'(dat), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst tx", 64'(tx), 64'd1);
    check("clk pass", 64'(clk_o), 64'(clk));
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (5) @(negedge clk);

    wd_q = '{32'h12345678, 32'hDEADBEEF};
    make_frame(1'b0, 2, 8'h00);
    fr_q[fr_q.size() - 1] = 8'hFF;
    expect_words(1'b0, 2);
    send_frame(-1, -1, 0);
    settle("bad csum", NAK);

    make_frame(1'b0, 2, 8'h00);
    expect_words(1'b0, 2);
    model_done = 1'b1;
    send_frame(-1, -1, 0);
    settle("two word", ACK);

    wd_q.delete();
    make_frame(1'b1, 0, 8'h00);
    send_frame(-1, -1, 0);
    settle("zero count", ACK);

    wd_q = '{32'h11223344};
    make_frame(1'b1, 1, 8'h00);
    expect_words(1'b1, 1);
    send_frame(-1, -1, 0);
    settle("data word", ACK);

    wd_q = '{32'h12345678, 32'hDEADBEEF};
    make_frame(1'b0, 2, 8'h00);
    send_frame(2, -1, 0);
    settle("stop err", NAK);
    rand_frame("after stop err", 1'b0);

    wd_q = '{32'h12345678, 32'hDEADBEEF};
    make_frame(1'b0, 2, 8'h00);
    send_frame(-1, 3, 60);
    settle("timeout", NAK);
    rand_frame("after timeout", 1'b0);

    wd_q.delete();
    make_frame(1'b0, 16'h4001, 8'h00);
    while (fr_q.size() > 4) void'(fr_q.pop_back());
    send_frame(-1, -1, 0);
    settle("oversize", NAK);
    rand_frame("after oversize", 1'b0);

    for (int i = 0; i < 4; i++) rand_frame("random", ($urandom_range(0, 3) == 0));

    wd_q = '{$urandom};
    make_frame(1'b0, 1, 8'h00);
    for (int i = 0; i < 6; i++) send_byte(fr_q[i], 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_done = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    check("mid rst adr", 64'(adr), 64'd0);
    check("mid rst dat", 64'(dat), 64'd0);
    check("mid rst done", 64'(done), 64'd0);
    check("mid rst writes", 64'(got_q.size()), 64'd0);
    got_q.delete();
    tx_q.delete();

    wd_q = '{$urandom, $urandom};
    make_frame(1'b1, 2, 8'h00);
    expect_words(1'b1, 2);
    model_done = 1'b1;
    send_frame(-1, -1, 0);
    settle("after reset", ACK);

    check("strobe width", 64'(wen_long), 64'd0);
    check("write hold", 64'(unstable), 64'd0);
    check("tx framing", 64'(tx_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
